// File: rtl/zkr_seed_ctrl.sv
// zkr_seed_ctrl: seed controller for the Zkr `seed` CSR.
// Health-tests the 8-bit entropy byte stream, packs accepted bytes into
// seeds, buffers them in a small FIFO and presents the OPST/seed word.
// Optional feature: define ZKR_APT_EN to add the adaptive proportion test
// (64-byte windows, failure at 13 hits of the window's first byte).
module zkr_seed_ctrl #(
   parameter int SEED_BITS     = 16,
   parameter int FIFO_DEPTH    = 2,
   parameter int BIST_SAMPLES  = 64,
   parameter int RCT_CUTOFF    = 8,
   parameter int BIST_MAX_FAIL = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        src_valid_i,
   input  logic [7:0]  src_data_i,
   input  logic [1:0]  src_error_i,
   output logic        src_enable_o,
   input  logic        seed_rd_i,
   output logic [31:0] seed_o,
   output logic        dead_o
);

   localparam int NB  = SEED_BITS / 8;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int SCW = $clog2(BIST_SAMPLES + 1);
   localparam int RCW = $clog2(RCT_CUTOFF + 1);
   localparam int FCW = $clog2(BIST_MAX_FAIL + 1);

   // State encoding doubles as the OPST field of the seed word.
   typedef enum logic [1:0] {
      ST_BIST = 2'b00,
      ST_WAIT = 2'b01,
      ST_ES16 = 2'b10,
      ST_DEAD = 2'b11
   } state_t;

   state_t state, state_d;

   logic [SEED_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]        rd_ptr, wr_ptr;
   logic [CW-1:0]        fifo_cnt;
   logic                 fifo_full, fifo_empty;

   logic [SEED_BITS-1:0] asm_sr, asm_word;
   logic [BCW-1:0]       byte_cnt;
   logic                 last_byte;

   logic [7:0]           rct_prev;
   logic                 rct_have;
   logic [RCW-1:0]       rct_cnt, rct_next;
   logic                 rct_fail, apt_fail;

   logic [SCW-1:0]       samp_cnt;
   logic [FCW-1:0]       fail_cnt;

   logic hard_err, soft_err, src_ok;
   logic bist_byte, acc_byte, test_byte, health_fail;
   logic flush_all, health_clr, asm_clr, asm_take, push, pop;
   logic samp_clr, samp_inc, fail_inc, fail_clr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt == '0);

   assign hard_err = src_error_i[0];
   assign soft_err = (src_error_i == 2'b10);
   assign src_ok   = (src_error_i == 2'b00);

   // BIST bytes ignore the FIFO; delivery bytes are dropped while it is full.
   assign bist_byte = src_valid_i && src_ok && (state == ST_BIST);
   assign acc_byte  = src_valid_i && src_ok && !fifo_full &&
                      ((state == ST_WAIT) || (state == ST_ES16));
   assign test_byte = bist_byte || acc_byte;

   assign rct_next = (rct_have && (src_data_i == rct_prev))
                   ? ((rct_cnt == RCW'(RCT_CUTOFF)) ? rct_cnt : rct_cnt + RCW'(1))
                   : RCW'(1);
   assign rct_fail    = test_byte && (rct_next == RCW'(RCT_CUTOFF));
   assign health_fail = rct_fail || apt_fail;

   // First byte of a seed ends up in the most-significant byte.
   assign asm_word  = SEED_BITS'({asm_sr, src_data_i});
   assign last_byte = (byte_cnt == BCW'(NB - 1));

   // Next-state and control strobes; errors outrank push, pop and health results.
   always_comb begin
      state_d    = state;
      flush_all  = 1'b0;
      health_clr = 1'b0;
      asm_clr    = 1'b0;
      asm_take   = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      samp_clr   = 1'b0;
      samp_inc   = 1'b0;
      fail_inc   = 1'b0;
      fail_clr   = 1'b0;
      if (state != ST_DEAD) begin
         if (hard_err) begin
            state_d    = ST_BIST;
            flush_all  = 1'b1;
            health_clr = 1'b1;
            samp_clr   = 1'b1;
         end else if (state == ST_BIST) begin
            if (health_fail) begin
               health_clr = 1'b1;
               samp_clr   = 1'b1;
               fail_inc   = 1'b1;
               if (fail_cnt == FCW'(BIST_MAX_FAIL - 1))
                  state_d = ST_DEAD;
            end else if (bist_byte) begin
               if (samp_cnt == SCW'(BIST_SAMPLES - 1)) begin
                  state_d  = ST_WAIT;
                  samp_clr = 1'b1;
                  fail_clr = 1'b1;
               end else begin
                  samp_inc = 1'b1;
               end
            end
         end else if (soft_err && (state == ST_ES16)) begin
            state_d = ST_WAIT;
            asm_clr = 1'b1;
         end else if (health_fail) begin
            state_d    = ST_BIST;
            flush_all  = 1'b1;
            health_clr = 1'b1;
            samp_clr   = 1'b1;
         end else begin
            asm_take = acc_byte;
            push     = acc_byte && last_byte;
            pop      = (state == ST_ES16) && seed_rd_i && !fifo_empty;
            if ((state == ST_WAIT) && !fifo_empty)
               state_d = ST_ES16;
            else if ((state == ST_ES16) && pop && !push && (fifo_cnt == CW'(1)))
               state_d = ST_WAIT;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_BIST;
      else
         state <= state_d;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst || flush_all) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)
            fifo_cnt <= fifo_cnt + CW'(1);
         else if (pop && !push)
            fifo_cnt <= fifo_cnt - CW'(1);
      end
   end

   // FIFO storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= asm_word;
   end

   // Byte assembler: shifts in accepted bytes until a seed is complete.
   always_ff @(posedge clk) begin
      if (rst || flush_all || asm_clr) begin
         asm_sr   <= '0;
         byte_cnt <= '0;
      end else if (asm_take) begin
         if (last_byte) begin
            asm_sr   <= '0;
            byte_cnt <= '0;
         end else begin
            asm_sr   <= asm_word;
            byte_cnt <= byte_cnt + BCW'(1);
         end
      end
   end

   // Repetition-count history, restarted after any health failure.
   always_ff @(posedge clk) begin
      if (rst || health_clr) begin
         rct_prev <= '0;
         rct_have <= 1'b0;
         rct_cnt  <= '0;
      end else if (test_byte) begin
         rct_prev <= src_data_i;
         rct_have <= 1'b1;
         rct_cnt  <= rct_next;
      end
   end

   // BIST pass counter and consecutive-failure counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         samp_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         if (samp_clr)
            samp_cnt <= '0;
         else if (samp_inc)
            samp_cnt <= samp_cnt + SCW'(1);
         if (fail_clr)
            fail_cnt <= '0;
         else if (fail_inc)
            fail_cnt <= fail_cnt + FCW'(1);
      end
   end

`ifdef ZKR_APT_EN
   logic [5:0] apt_pos;
   logic [7:0] apt_ref;
   logic [3:0] apt_hits;

   assign apt_fail = test_byte && (apt_pos != 6'd0) &&
                     (src_data_i == apt_ref) && (apt_hits == 4'd12);

   // Adaptive proportion window; the first byte of each window is the reference.
   always_ff @(posedge clk) begin
      if (rst || health_clr) begin
         apt_pos  <= '0;
         apt_ref  <= '0;
         apt_hits <= '0;
      end else if (test_byte) begin
         apt_pos <= apt_pos + 6'd1;
         if (apt_pos == 6'd0) begin
            apt_ref  <= src_data_i;
            apt_hits <= 4'd1;
         end else if (src_data_i == apt_ref) begin
            apt_hits <= apt_hits + 4'd1;
         end
      end
   end
`else
   assign apt_fail = 1'b0;
`endif

   // CSR word: OPST on top, payload only while ES16 holds a seed.
   always_comb begin
      seed_o        = '0;
      seed_o[31:30] = state;
      if (state == ST_ES16)
         seed_o[SEED_BITS-1:0] = fifo_mem[rd_ptr];
   end

   assign dead_o       = (state == ST_DEAD);
   assign src_enable_o = (state != ST_DEAD) && !fifo_full;

endmodule
